// File: rtl/wb_mem_tester.sv
// Wishbone classic master memory self-test: writes a seeded pattern over a word
// range, reads it back, and reports mismatches and bus timeouts.
module wb_mem_tester #(
  parameter logic [31:0] START_ADDR = 32'h0000_0000,
  parameter int          WORD_COUNT = 256,
  parameter logic [31:0] SEED       = 32'hA5A5_5A5A,
  parameter int          TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [15:0] err_count,
  output logic [31:0] err_addr,
  output logic [31:0] err_data,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [31:0] wbm_addr_o,
  output logic [2:0]  wbm_cti_o,
  output logic [1:0]  wbm_bte_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_data_o,
  input  logic [31:0] wbm_data_i,
  input  logic        wbm_ack_i
);
  typedef enum logic [2:0] {IDLE, WR, WR_GAP, RD, RD_GAP, DONE} state_t;

  localparam logic [15:0] LAST_IDX = 16'(WORD_COUNT - 1);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

  state_t      state, state_next;
  logic        start_prev;
  logic [15:0] idx;
  logic [31:0] tcnt;
  logic        start_go, acked, tmo_hit, last, mismatch;
  logic [31:0] pat_cur;

  function automatic logic [31:0] pattern(input logic [15:0] i);
    return {i, ~i} ^ SEED;
  endfunction

  function automatic logic [31:0] word_addr(input logic [15:0] i);
    return START_ADDR + {14'd0, i, 2'b00};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  assign wbm_stb_o = wbm_cyc_o;
  assign wbm_cti_o = 3'b000;
  assign wbm_bte_o = 2'b00;
  assign wbm_sel_o = 4'b1111;

  always_comb begin
    start_go   = start & ~start_prev & ((state == IDLE) || (state == DONE));
    acked      = wbm_cyc_o & wbm_ack_i;
    tmo_hit    = wbm_cyc_o & ~wbm_ack_i & (tcnt == TMO_LAST);
    last       = (idx == LAST_IDX);
    pat_cur    = pattern(idx);
    mismatch   = acked & (state == RD) & (wbm_data_i != pat_cur);
    state_next = state;
    case (state)
      IDLE, DONE: if (start_go) state_next = WR;
      WR: begin
        if (acked)        state_next = last ? RD : WR_GAP;
        else if (tmo_hit) state_next = DONE;
      end
      WR_GAP: state_next = WR;
      RD: begin
        if (acked)        state_next = last ? DONE : RD_GAP;
        else if (tmo_hit) state_next = DONE;
      end
      RD_GAP: state_next = RD;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Bus and status registers; cyc/stb are asserted on the first cycle spent
  // in WR/RD with the bus idle, so every access is preceded by an idle cycle.
  always_ff @(posedge clk) begin
    start_prev <= start;
    if (!rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
      err_count  <= 16'd0;
      err_addr   <= 32'd0;
      err_data   <= 32'd0;
      idx        <= 16'd0;
      tcnt       <= 32'd0;
      wbm_cyc_o  <= 1'b0;
      wbm_we_o   <= 1'b0;
      wbm_addr_o <= 32'd0;
      wbm_data_o <= 32'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_go) begin
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            err_count <= 16'd0;
            err_addr  <= 32'd0;
            err_data  <= 32'd0;
            idx       <= 16'd0;
          end
        end
        WR, RD: begin
          if (!wbm_cyc_o) begin
            wbm_cyc_o  <= 1'b1;
            wbm_we_o   <= (state == WR);
            wbm_addr_o <= word_addr(idx);
            if (state == WR) wbm_data_o <= pat_cur;
            tcnt <= 32'd0;
          end else if (acked) begin
            wbm_cyc_o <= 1'b0;
            idx       <= last ? 16'd0 : idx + 16'd1;
            if (mismatch) begin
              err_count <= sat_inc(err_count);
              if (err_count == 16'd0) begin
                err_addr <= wbm_addr_o;
                err_data <= wbm_data_i;
              end
            end
            if ((state == RD) && last) begin
              busy <= 1'b0;
              done <= 1'b1;
              pass <= (err_count == 16'd0) && !mismatch;
            end
          end else if (tmo_hit) begin
            wbm_cyc_o <= 1'b0;
            timeout   <= 1'b1;
            pass      <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
          end else begin
            tcnt <= tcnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_mem_tester.sv
// Bench for wb_mem_tester: table of slave behaviours checked against a
// pattern/readback reference model, plus start-edge and reset sequences.
module tb_wb_mem_tester;
  localparam logic [31:0] START = 32'hFFFF_FE00;  // range wraps past 2^32
  localparam int          N     = 300;
  localparam logic [31:0] SEED  = 32'hA5A5_5A5A;
  localparam int          TMO   = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b1;
  logic        busy, done, pass, timeout;
  logic [15:0] err_count;
  logic [31:0] err_addr, err_data;
  logic        cyc, stb, we;
  logic [31:0] addr, wdata;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [3:0]  sel;
  logic [31:0] rdata = 32'd0;
  logic        ack = 1'b0;

  always #5 clk = ~clk;

  wb_mem_tester #(
    .START_ADDR(START), .WORD_COUNT(N), .SEED(SEED), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .err_count(err_count), .err_addr(err_addr), .err_data(err_data),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_addr_o(addr), .wbm_cti_o(cti),
    .wbm_bte_o(bte), .wbm_sel_o(sel), .wbm_we_o(we), .wbm_data_o(wdata),
    .wbm_data_i(rdata), .wbm_ack_i(ack)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    logic [15:0] k;
    k = 16'(i);
    return {k, ~k} ^ SEED;
  endfunction

  // Slave behaviour knobs and observations
  int lat_max = 0, fault_idx = -1, fault_bit = 0, hang_at = -1;
  bit spurious = 1'b0;
  int acc_no = 0, lat_sum = 0, hang_cyc = 0, viol = 0, cyc_cnt = 0;
  int lat_left = 0, cur_lat = 0, widx = 0;
  bit in_acc = 1'b0, prev_cyc = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
  logic [31:0] prev_addr = 32'd0, prev_data = 32'd0;
  logic [31:0] mem [0:1023];

  typedef struct packed { logic we; logic [31:0] addr; logic [31:0] data; } xfer_t;
  xfer_t xq[$];

  // Memory slave with programmable wait states, a stuck-at-1 read fault,
  // a hang point, and optional acks while the bus is idle; also watches protocol.
  always @(negedge clk) begin
    if (cyc !== stb || cti !== 3'b000 || bte !== 2'b00 || sel !== 4'hF) viol++;
    if (prev_cyc && prev_ack && cyc) viol++;
    if (prev_cyc && !prev_ack && cyc &&
        (addr !== prev_addr || we !== prev_we || (we && wdata !== prev_data))) viol++;
    ack = 1'b0;
    rdata = 32'd0;
    if (!cyc) begin
      in_acc = 1'b0;
      if (spurious && $urandom_range(0, 3) == 0) begin
        ack = 1'b1;
        rdata = $urandom;
      end
    end else begin
      cyc_cnt++;
      if (!in_acc) begin
        in_acc = 1'b1;
        lat_left = $urandom_range(0, lat_max);
        cur_lat = lat_left;
      end
      if (acc_no == hang_at) hang_cyc++;
      else if (lat_left > 0) lat_left--;
      else begin
        ack = 1'b1;
        widx = int'((addr - START) >> 2);
        if (we) mem[addr[11:2]] = wdata;
        else begin
          rdata = mem[addr[11:2]];
          if (fault_idx == -2 || fault_idx == widx) rdata[fault_bit] = 1'b1;
        end
        xq.push_back('{we, addr, we ? wdata : rdata});
        lat_sum += cur_lat;
        acc_no++;
      end
    end
    prev_cyc = cyc; prev_ack = ack && cyc; prev_we = we; prev_addr = addr; prev_data = wdata;
  end

  typedef struct packed {
    int lat_max; int fault_idx; int fault_bit; int hang_at;
    bit spurious; bit exp_pass; bit exp_timeout;
  } vec_t;
  vec_t vecs [8];

  task automatic configure(input vec_t v);
    lat_max = v.lat_max; fault_idx = v.fault_idx; fault_bit = v.fault_bit;
    hang_at = v.hang_at; spurious = v.spurious;
  endtask

  task automatic launch();
    acc_no = 0; lat_sum = 0; hang_cyc = 0; viol = 0; cyc_cnt = 0;
    xq.delete();
    start = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_done(input string tag, output int busy_cyc);
    busy_cyc = 0;
    for (int c = 0; c < 20000 && !done; c++) begin
      if (busy) busy_cyc++;
      @(negedge clk);
    end
    check({tag, "_done_reached"}, 32'(done), 32'd1);
  endtask

  task automatic verify(input vec_t v, input string tag, input int busy_cyc);
    int exp_acks, reads, ecnt, bad;
    logic [31:0] eaddr, edata, got;
    exp_acks = (v.hang_at >= 0) ? v.hang_at : 2 * N;
    check({tag, "_acks"}, 32'(xq.size()), 32'(exp_acks));
    bad = 0;
    foreach (xq[j]) begin
      if (j < N) begin
        if (xq[j].we !== 1'b1 || xq[j].addr !== START + 32'(4 * j) || xq[j].data !== pat(j)) bad++;
      end else if (xq[j].we !== 1'b0 || xq[j].addr !== START + 32'(4 * (j - N))) bad++;
    end
    check({tag, "_bus_seq"}, 32'(bad), 32'd0);
    reads = (exp_acks > N) ? exp_acks - N : 0;
    ecnt = 0; eaddr = 32'd0; edata = 32'd0;
    for (int i = 0; i < reads; i++) begin
      got = pat(i);
      if (v.fault_idx == -2 || v.fault_idx == i) got[v.fault_bit] = 1'b1;
      if (got != pat(i)) begin
        if (ecnt == 0) begin eaddr = START + 32'(4 * i); edata = got; end
        ecnt++;
      end
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'(v.exp_pass));
    check({tag, "_pass_model"}, 32'(pass), 32'(ecnt == 0 && v.hang_at < 0));
    check({tag, "_timeout"}, 32'(timeout), 32'(v.exp_timeout));
    check({tag, "_err_count"}, 32'(err_count), 32'(ecnt));
    check({tag, "_err_addr"}, err_addr, eaddr);
    check({tag, "_err_data"}, err_data, edata);
    check({tag, "_protocol"}, 32'(viol), 32'd0);
    // Every access costs wait states + strobe + two idle cycles; the run skips
    // the gap after the last read and the write-to-read hand-over saves one.
    if (v.hang_at < 0) check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(3 * exp_acks + lat_sum - 2));
    else               check({tag, "_strobe_to_timeout"}, 32'(hang_cyc), 32'(TMO));
  endtask

  initial begin
    int bc;
    vec_t clean;
    vecs[0] = '{0, -1, 0, -1,      1'b0, 1'b1, 1'b0};
    vecs[1] = '{1, -1, 0, -1,      1'b0, 1'b1, 1'b0};
    vecs[2] = '{3, -1, 0, -1,      1'b1, 1'b1, 1'b0};
    vecs[3] = '{0, 5, 3, -1,       1'b0, 1'b0, 1'b0};
    vecs[4] = '{2, -2, 0, -1,      1'b1, 1'b0, 1'b0};
    vecs[5] = '{0, -1, 0, 0,       1'b0, 1'b0, 1'b1};
    vecs[6] = '{1, 5, 3, N + 10,   1'b0, 1'b0, 1'b1};
    vecs[7] = '{3, 299, 30, -1,    1'b1, 1'b0, 1'b0};
    clean   = '{2, -1, 0, -1,      1'b1, 1'b1, 1'b0};

    // Reset with start held high
    repeat (3) @(negedge clk);
    check("reset_status", {28'd0, busy, done, pass, timeout}, 32'd0);
    check("reset_bus", {29'd0, cyc, stb, we}, 32'd0);
    check("reset_err_count", 32'(err_count), 32'd0);
    check("reset_err_addr", err_addr, 32'd0);
    check("reset_addr_data", addr | wdata, 32'd0);
    cyc_cnt = 0;
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("held_start_no_run", 32'(cyc_cnt + int'(busy)), 32'd0);

    for (int k = 0; k < 8; k++) begin
      start = 1'b0;
      configure(vecs[k]);
      repeat (2) @(negedge clk);
      launch();
      wait_done($sformatf("v%0d", k), bc);
      verify(vecs[k], $sformatf("v%0d", k), bc);
    end

    // Start held high after a failing run must not relaunch
    cyc_cnt = 0;
    repeat (20) @(negedge clk);
    check("hold_no_rerun", 32'(cyc_cnt), 32'd0);
    check("hold_done", 32'(done), 32'd1);
    start = 1'b0;
    configure(clean);
    repeat (2) @(negedge clk);
    launch();
    check("restart_clears", {busy, done, pass, timeout, err_count}, {4'b1000, 16'd0});
    check("restart_err_addr", err_addr | err_data, 32'd0);
    wait_done("rerun", bc);
    verify(clean, "rerun", bc);

    // Reset during a read wait
    start = 1'b0;
    configure('{0, -1, 0, N + 2, 1'b0, 1'b0, 1'b1});
    repeat (2) @(negedge clk);
    launch();
    for (int c = 0; c < 5000 && hang_cyc < 3; c++) @(negedge clk);
    check("read_wait_reached", 32'(hang_cyc >= 3 && !we && cyc), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("midrun_rst_bus", {29'd0, cyc, stb, we}, 32'd0);
    check("midrun_rst_status", {12'd0, busy, done, pass, timeout, err_count}, 32'd0);
    check("midrun_rst_err", err_addr | err_data | addr | wdata, 32'd0);
    rst = 1'b1;
    cyc_cnt = 0;
    repeat (20) @(negedge clk);
    check("post_rst_no_run", 32'(cyc_cnt + int'(busy)), 32'd0);
    start = 1'b0;
    configure(clean);
    repeat (2) @(negedge clk);
    launch();
    wait_done("post_rst", bc);
    verify(clean, "post_rst", bc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
